// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request bundle from EX/MEM plus the data-memory port.
// master = pipeline/memory side, slave = mem_access_unit.
// Request signals: req_load, req_store, size, unsigned_load, addr, store_data.
// Memory signals: mem_address, mem_in_data, mem_write, mem_read, mem_out_data.
// Status signals: load_data, done, error, busy.
interface mem_access_unit_if #(
    parameter int ADDR_BITS = 11
);
    logic                 req_load;
    logic                 req_store;
    logic [1:0]           size;
    logic                 unsigned_load;
    logic [31:0]          addr;
    logic [31:0]          store_data;
    logic [31:0]          mem_out_data;
    logic [ADDR_BITS-1:0] mem_address;
    logic [31:0]          mem_in_data;
    logic                 mem_write;
    logic                 mem_read;
    logic [31:0]          load_data;
    logic                 done;
    logic                 error;
    logic                 busy;

    modport master (
        output req_load, req_store, size, unsigned_load,
        output addr, store_data, mem_out_data,
        input  mem_address, mem_in_data, mem_write, mem_read,
        input  load_data, done, error, busy
    );

    modport slave (
        input  req_load, req_store, size, unsigned_load,
        input  addr, store_data, mem_out_data,
        output mem_address, mem_in_data, mem_write, mem_read,
        output load_data, done, error, busy
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store controller for a word memory.
// Ports: clock, reset (async active-low), bus (mem_access_unit_if.slave).
// Sub-word stores use read-modify-write; sub-word loads are sign/zero
// extended. busy is high while an access is in flight.
module mem_access_unit #(
    parameter int ADDR_BITS = 11
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_unit_if.slave bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ACCESS    = 2'd1;
    localparam logic [1:0] S_RMW_READ  = 2'd2;
    localparam logic [1:0] S_RMW_WRITE = 2'd3;

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_mem_address;
    logic [31:0]          r_mem_in_data;
    logic [31:0]          r_load_data;
    logic                 r_done;
    logic                 r_error;
    logic [1:0]           r_addr_lo;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic                 r_is_store;
    logic [15:0]          r_store_data;

    logic                 w_req;
    logic                 w_bad;
    logic                 w_word_st;
    logic [7:0]           w_lane_b;
    logic [15:0]          w_lane_h;
    logic [31:0]          w_load_ext;
    logic [31:0]          w_merged;
    logic                 w_unused;

    // Address bits above the memory range are ignored (wrap).
    assign w_unused = ^bus.addr[31:ADDR_BITS+2];

    assign w_req = bus.req_load | bus.req_store;

    assign w_bad = (bus.req_load & bus.req_store)
                 | (bus.size == 2'b11)
                 | ((bus.size == 2'b01) & bus.addr[0])
                 | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00));

    assign w_word_st = bus.req_store & (bus.size == 2'b10);

    always_comb begin
        w_lane_b = bus.mem_out_data[7:0];
        case (r_addr_lo)
            2'd1:    w_lane_b = bus.mem_out_data[15:8];
            2'd2:    w_lane_b = bus.mem_out_data[23:16];
            2'd3:    w_lane_b = bus.mem_out_data[31:24];
            default: w_lane_b = bus.mem_out_data[7:0];
        endcase
        w_lane_h = r_addr_lo[1] ? bus.mem_out_data[31:16]
                                : bus.mem_out_data[15:0];
    end

    always_comb begin
        w_load_ext = bus.mem_out_data;
        case (r_size)
            2'b00: w_load_ext = {{24{~r_unsigned & w_lane_b[7]}}, w_lane_b};
            2'b01: w_load_ext = {{16{~r_unsigned & w_lane_h[15]}}, w_lane_h};
            default: w_load_ext = bus.mem_out_data;
        endcase
    end

    // Only byte and halfword stores reach the RMW path.
    always_comb begin
        w_merged = bus.mem_out_data;
        if (r_size == 2'b00) begin
            case (r_addr_lo)
                2'd0: w_merged[7:0]   = r_store_data[7:0];
                2'd1: w_merged[15:8]  = r_store_data[7:0];
                2'd2: w_merged[23:16] = r_store_data[7:0];
                2'd3: w_merged[31:24] = r_store_data[7:0];
                default: w_merged = bus.mem_out_data;
            endcase
        end else if (r_addr_lo[1]) begin
            w_merged[31:16] = r_store_data;
        end else begin
            w_merged[15:0] = r_store_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_mem_address <= '0;
            r_mem_in_data <= '0;
            r_load_data   <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_addr_lo     <= 2'b00;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_is_store    <= 1'b0;
            r_store_data  <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_bad) begin
                            r_error <= 1'b1;
                        end else begin
                            r_mem_address <= bus.addr[ADDR_BITS+1:2];
                            r_addr_lo     <= bus.addr[1:0];
                            r_size        <= bus.size;
                            r_unsigned    <= bus.unsigned_load;
                            r_is_store    <= bus.req_store;
                            r_store_data  <= bus.store_data[15:0];
                            if (w_word_st) begin
                                r_mem_in_data <= bus.store_data;
                                r_state       <= S_ACCESS;
                            end else if (bus.req_store) begin
                                r_state <= S_RMW_READ;
                            end else begin
                                r_state <= S_ACCESS;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_is_store) begin
                        r_load_data <= w_load_ext;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_RMW_READ: begin
                    r_mem_in_data <= w_merged;
                    r_state       <= S_RMW_WRITE;
                end
                S_RMW_WRITE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset kills them at once.
    assign bus.mem_read  = ((r_state == S_ACCESS) & ~r_is_store)
                         | (r_state == S_RMW_READ);
    assign bus.mem_write = ((r_state == S_ACCESS) & r_is_store)
                         | (r_state == S_RMW_WRITE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.mem_address = r_mem_address;
    assign bus.mem_in_data = r_mem_in_data;
    assign bus.load_data   = r_load_data;
    assign bus.done        = r_done;
    assign bus.error       = r_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store checks against a
// byte-array reference model of the data memory.
module tb_mem_access_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_access_unit_if #(.ADDR_BITS(11)) bus();

    mem_access_unit #(.ADDR_BITS(11)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] tb_mem    [0:2047];
    logic [7:0]  ref_bytes [0:8191];
    logic [31:0] ref_load;
    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        v = 32'(i);
        return (v * 32'h9E3779B1) ^ 32'hA5C30F17;
    endfunction

    // Behavioural memory: latches read data at negedge, writes at posedge.
    initial begin
        for (int i = 0; i < 2048; i++) tb_mem[i] = init_word(i);
        forever begin
            @(posedge clock);
            if (bus.mem_write) begin
                tb_mem[bus.mem_address] = bus.mem_in_data;
                wr_cnt++;
            end
            if (bus.mem_read) rd_cnt++;
        end
    end

    always @(negedge clock)
        if (bus.mem_read) bus.mem_out_data <= tb_mem[bus.mem_address];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_word(input int wi);
        return {ref_bytes[4*wi+3], ref_bytes[4*wi+2],
                ref_bytes[4*wi+1], ref_bytes[4*wi]};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a,
                                               input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] v;
        int n;
        int b;
        v = '0;
        n = nbytes(sz);
        b = int'(a[12:0]);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[b+i];
        if (n < 4 && !uns && v[8*n-1])
            for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
        return v;
    endfunction

    function automatic logic model_legal(input logic ld, input logic st,
                                         input logic [1:0] sz,
                                         input logic [31:0] a);
        if (ld && st) return 1'b0;
        if (sz == 2'b11) return 1'b0;
        if (sz == 2'b01 && a[0]) return 1'b0;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] d);
        int b;
        b = int'(a[12:0]);
        for (int i = 0; i < nbytes(sz); i++) ref_bytes[b+i] = d[8*i +: 8];
    endtask

    // Drives one request and measures the response; no checking here.
    task automatic issue(input logic ld, input logic st,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic err,
                         output int bcyc, output int nwr, output int nrd);
        int w0;
        int r0;
        int k;
        k = 0;
        while (bus.busy && k < 20) begin
            @(posedge clock); #1; k++;
        end
        w0 = wr_cnt;
        r0 = rd_cnt;
        bus.req_load      = ld;
        bus.req_store     = st;
        bus.size          = sz;
        bus.unsigned_load = uns;
        bus.addr          = a;
        bus.store_data    = d;
        @(posedge clock); #1;
        bus.req_load  = 1'b0;
        bus.req_store = 1'b0;
        err  = bus.error;
        lat  = -1;
        bcyc = 0;
        k    = 1;
        if (bus.busy) begin
            while (k < 12) begin
                if (bus.busy) bcyc++;
                @(posedge clock); #1; k++;
                if (bus.done) begin
                    lat = k;
                    break;
                end
            end
        end
        nwr = wr_cnt - w0;
        nrd = rd_cnt - r0;
    endtask

    int          lat, bcyc, nwr, nrd;
    logic        err;

    task automatic test_reset;
        #10;
        n_checks++;
        if ({bus.mem_write, bus.mem_read, bus.busy, bus.done, bus.error}
            !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.mem_write, bus.mem_read, bus.busy, bus.done,
                      bus.error});
        end
        n_checks++;
        if ({bus.load_data, bus.mem_in_data, bus.mem_address} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: load %h in %h addr %h expected 0",
                     bus.load_data, bus.mem_in_data, bus.mem_address);
        end
        #5 reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_word_store;
        issue(0, 1, 2'b10, 0, 32'h10, 32'h11223344, lat, err, bcyc, nwr, nrd);
        model_store(32'h10, 2'b10, 32'h11223344);
        n_checks++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL wst_latency: got %0d expected 2", lat);
        end
        n_checks++;
        if (bcyc !== 1 || nwr !== 1) begin
            n_fail++;
            $display("FAIL wst_busy_wr: busy %0d writes %0d expected 1 1",
                     bcyc, nwr);
        end
        n_checks++;
        if (bus.mem_address !== 11'd4) begin
            n_fail++;
            $display("FAIL wst_addr: got %0d expected 4", bus.mem_address);
        end
        n_checks++;
        if (tb_mem[4] !== 32'h11223344) begin
            n_fail++;
            $display("FAIL wst_mem: got %h expected 11223344", tb_mem[4]);
        end
    endtask

    task automatic test_byte_rmw;
        issue(0, 1, 2'b00, 0, 32'h11, 32'hFFFFFFAB, lat, err, bcyc, nwr, nrd);
        model_store(32'h11, 2'b00, 32'hFFFFFFAB);
        n_checks++;
        if (lat !== 3 || bcyc !== 2) begin
            n_fail++;
            $display("FAIL rmw_timing: lat %0d busy %0d expected 3 2",
                     lat, bcyc);
        end
        n_checks++;
        if (nwr !== 1 || nrd !== 1) begin
            n_fail++;
            $display("FAIL rmw_strobes: wr %0d rd %0d expected 1 1", nwr, nrd);
        end
        n_checks++;
        if (tb_mem[4] !== 32'h1122AB44) begin
            n_fail++;
            $display("FAIL rmw_mem: got %h expected 1122ab44", tb_mem[4]);
        end
    endtask

    task automatic test_loads;
        issue(1, 0, 2'b00, 0, 32'h11, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (bus.load_data !== 32'hFFFFFFAB || lat !== 2) begin
            n_fail++;
            $display("FAIL lb_signed: got %h lat %0d expected ffffffab 2",
                     bus.load_data, lat);
        end
        issue(1, 0, 2'b00, 1, 32'h11, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (bus.load_data !== 32'h000000AB) begin
            n_fail++;
            $display("FAIL lbu: got %h expected 000000ab", bus.load_data);
        end
        issue(1, 0, 2'b01, 0, 32'h12, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (bus.load_data !== 32'h00001122) begin
            n_fail++;
            $display("FAIL lh_pos: got %h expected 00001122", bus.load_data);
        end
        ref_load = 32'h00001122;
    endtask

    task automatic test_half;
        issue(0, 1, 2'b01, 0, 32'h12, 32'h12348001, lat, err, bcyc, nwr, nrd);
        model_store(32'h12, 2'b01, 32'h12348001);
        n_checks++;
        if (tb_mem[4] !== 32'h8001AB44) begin
            n_fail++;
            $display("FAIL sh_mem: got %h expected 8001ab44", tb_mem[4]);
        end
        issue(1, 0, 2'b01, 0, 32'h12, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (bus.load_data !== 32'hFFFF8001) begin
            n_fail++;
            $display("FAIL lh_neg: got %h expected ffff8001", bus.load_data);
        end
        ref_load = 32'hFFFF8001;
    endtask

    task automatic test_errors;
        issue(1, 0, 2'b10, 0, 32'h06, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (err !== 1'b1 || nwr !== 0 || nrd !== 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_misalign: err %b wr %0d rd %0d busy %b",
                     err, nwr, nrd, bus.busy);
        end
        n_checks++;
        if (bus.load_data !== ref_load) begin
            n_fail++;
            $display("FAIL err_keep_load: got %h expected %h",
                     bus.load_data, ref_load);
        end
        @(posedge clock); #1;
        n_checks++;
        if (bus.error !== 1'b0) begin
            n_fail++; $display("FAIL err_pulse: got %b expected 0", bus.error);
        end
        issue(1, 1, 2'b10, 0, 32'h10, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (err !== 1'b1 || nwr !== 0) begin
            n_fail++; $display("FAIL err_both: err %b wr %0d", err, nwr);
        end
        issue(0, 1, 2'b11, 0, 32'h10, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (err !== 1'b1 || nwr !== 0) begin
            n_fail++; $display("FAIL err_size11: err %b wr %0d", err, nwr);
        end
        issue(1, 0, 2'b01, 0, 32'h13, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (err !== 1'b1 || nrd !== 0) begin
            n_fail++; $display("FAIL err_half_odd: err %b rd %0d", err, nrd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        d = $urandom;
        issue(0, 1, 2'b10, 0, 32'h20, d, lat, err, bcyc, nwr, nrd);
        model_store(32'h20, 2'b10, d);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: done %b busy %b expected 1 0",
                     bus.done, bus.busy);
        end
        issue(1, 0, 2'b10, 0, 32'h20, 32'h0, lat, err, bcyc, nwr, nrd);
        ref_load = model_load(32'h20, 2'b10, 1'b0);
        n_checks++;
        if (bus.load_data !== ref_load || lat !== 2) begin
            n_fail++;
            $display("FAIL b2b_load: got %h lat %0d expected %h 2",
                     bus.load_data, lat, ref_load);
        end
    endtask

    task automatic test_random;
        logic        ld, st, uns, legal;
        logic [1:0]  sz;
        logic [31:0] a, d, exp;
        int          op, exp_lat;
        for (int it = 0; it < 80; it++) begin
            op  = int'($urandom_range(0, 9));
            ld  = (op <= 4);
            st  = (op == 0) || (op >= 5);
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = $urandom & 32'hFFFFE03F;
            d   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            legal   = model_legal(ld, st, sz, a);
            exp_lat = (st && sz != 2'b10) ? 3 : 2;
            issue(ld, st, sz, uns, a, d, lat, err, bcyc, nwr, nrd);
            n_checks++;
            if (err !== !legal) begin
                n_fail++;
                $display("FAIL rnd_err[%0d]: got %b expected %b", it, err,
                         !legal);
            end
            if (legal) begin
                n_checks++;
                if (lat !== exp_lat) begin
                    n_fail++;
                    $display("FAIL rnd_lat[%0d]: got %0d expected %0d",
                             it, lat, exp_lat);
                end
                if (st) model_store(a, sz, d);
                else ref_load = model_load(a, sz, uns);
            end
            exp = ref_load;
            n_checks++;
            if (bus.load_data !== exp) begin
                n_fail++;
                $display("FAIL rnd_load[%0d]: got %h expected %h a=%h sz=%0d",
                         it, bus.load_data, exp, a, sz);
            end
        end
        for (int w = 0; w < 16; w++) begin
            n_checks++;
            if (tb_mem[w] !== model_word(w)) begin
                n_fail++;
                $display("FAIL rnd_mem[%0d]: got %h expected %h", w,
                         tb_mem[w], model_word(w));
            end
        end
    endtask

    task automatic test_reset_mid_rmw;
        logic [31:0] prior;
        prior = model_word(4);
        bus.req_store  = 1'b1;
        bus.size       = 2'b00;
        bus.addr       = 32'h10;
        bus.store_data = 32'h0000005A;
        @(posedge clock); #1;
        bus.req_store = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: busy %b rd %b expected 1 1",
                     bus.busy, bus.mem_read);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_write, bus.mem_read, bus.busy, bus.done, bus.error,
             bus.load_data, bus.mem_in_data, bus.mem_address} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: wr %b rd %b busy %b ld %h in %h ad %h",
                     bus.mem_write, bus.mem_read, bus.busy, bus.load_data,
                     bus.mem_in_data, bus.mem_address);
        end
        @(posedge clock);
        @(posedge clock); #3;
        reset = 1'b1;
        n_checks++;
        if (tb_mem[4] !== prior) begin
            n_fail++;
            $display("FAIL rst_mem: got %h expected %h", tb_mem[4], prior);
        end
        issue(1, 0, 2'b10, 0, 32'h10, 32'h0, lat, err, bcyc, nwr, nrd);
        n_checks++;
        if (bus.load_data !== prior) begin
            n_fail++;
            $display("FAIL rst_reload: got %h expected %h",
                     bus.load_data, prior);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_load      = 1'b0;
        bus.req_store     = 1'b0;
        bus.size          = 2'b00;
        bus.unsigned_load = 1'b0;
        bus.addr          = '0;
        bus.store_data    = '0;
        ref_load          = '0;
        for (int wi = 0; wi < 2048; wi++) begin
            logic [31:0] w;
            w = init_word(wi);
            for (int j = 0; j < 4; j++) ref_bytes[4*wi+j] = w[8*j +: 8];
        end
        #2 reset = 1'b0;
        test_reset;
        test_word_store;
        test_byte_rmw;
        test_loads;
        test_half;
        test_errors;
        test_back_to_back;
        test_random;
        test_reset_mid_rmw;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
